// File: rtl/cd_rx_des_gen.sv
// cd_rx_des_gen -- CDBUS receive deserializer, dual-rate.
// Turns the synchronised rx line into DATA_W-bit words (LSB first) with a
// one-clock data_clk strobe. The first word of a frame is timed with div_ls;
// later words use div_hs until the bus goes idle again. It also provides bus
// idle qualification, break detection, stop-bit framing errors and a running
// reflected CRC-16.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   div_ls / div_hs       bit divider, bit period = div+1 clk
//   idle_wait_len         idle bit-times (LS) required before bus_idle
//   force_wait_idle       pulse: drop the current word, re-qualify idle
//   rx                    synchronised line level
//   data, data_clk        received word and its 1-clk strobe
//   crc_eq_zero           CRC including this word == 0, valid with data_clk
//   bus_idle              idle level
//   rx_break, frame_err   1-clk event pulses
module cd_rx_des_gen #(
  parameter int          DATA_W   = 8,
  parameter int          DIV_W    = 16,
  parameter int          IDLE_W   = 10,
  parameter logic [15:0] CRC_POLY = 16'hA001,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIV_W-1:0]  div_ls,
  input  logic [DIV_W-1:0]  div_hs,
  input  logic [IDLE_W-1:0] idle_wait_len,
  input  logic              force_wait_idle,
  input  logic              rx,
  output logic [DATA_W-1:0] data,
  output logic              data_clk,
  output logic              crc_eq_zero,
  output logic              bus_idle,
  output logic              rx_break,
  output logic              frame_err
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_WAIT_START, S_START, S_DATA, S_STOP, S_BREAK_CHK
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [DIV_W:0]      r_bit_tmr;
  logic [DIV_W-1:0]    r_div;
  logic [IDX_W-1:0]    r_bit_idx;
  logic [DATA_W-1:0]   r_sh;
  logic [DIV_W-1:0]    r_idle_tmr;
  logic [IDLE_W:0]     r_idle_cnt;
  logic                r_rate_hs;
  logic [15:0]         r_crc;
  logic                r_brk_done;

  logic [DIV_W-1:0]    w_div_sel;
  logic                w_tmr_zero, w_idle_st, w_idle_tick, w_idle_hit;
  logic [IDLE_W+1:0]   w_idle_inc, w_idle_tgt;
  logic [15:0]         w_crc_nxt;
  logic                w_start, w_start_ok, w_bit, w_stop_ok, w_stop_bad, w_brk;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [DATA_W-1:0] d);
    logic [15:0] x;
    x = c;
    for (int i = 0; i < DATA_W; i++) begin
      if (x[0] ^ d[i]) x = (x >> 1) ^ CRC_POLY;
      else             x = x >> 1;
    end
    return x;
  endfunction

  assign w_div_sel  = r_rate_hs ? div_hs : div_ls;
  assign w_tmr_zero = (r_bit_tmr == '0);
  assign w_crc_nxt  = crc_upd(r_crc, r_sh);

  // Idle qualification runs in LS bit-times regardless of the current rate.
  // The hit is taken on the tick that brings the count to idle_wait_len+1;
  // >= keeps a shrinking idle_wait_len from being skipped over.
  assign w_idle_st   = (r_state == S_WAIT_IDLE) || (r_state == S_WAIT_START);
  assign w_idle_tick = rx && (r_idle_tmr >= div_ls);
  assign w_idle_inc  = {1'b0, r_idle_cnt} + (IDLE_W+2)'(1);
  assign w_idle_tgt  = {2'b00, idle_wait_len} + (IDLE_W+2)'(1);
  assign w_idle_hit  = w_idle_st && w_idle_tick && (w_idle_inc >= w_idle_tgt);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_start_ok  = 1'b0;
    w_bit       = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    w_brk       = 1'b0;
    case (r_state)
      S_WAIT_IDLE:  if (w_idle_hit) w_state_nxt = S_WAIT_START;
      S_WAIT_START: if (!rx) begin w_start = 1'b1; w_state_nxt = S_START; end
      S_START: if (w_tmr_zero) begin
        if (rx) w_state_nxt = S_WAIT_START;          // glitch
        else begin w_start_ok = 1'b1; w_state_nxt = S_DATA; end
      end
      S_DATA: if (w_tmr_zero) begin
        w_bit = 1'b1;
        if (r_bit_idx == IDX_W'(DATA_W-1)) w_state_nxt = S_STOP;
      end
      S_STOP: if (w_tmr_zero) begin
        if (rx) begin w_stop_ok = 1'b1; w_state_nxt = S_WAIT_START; end
        else begin w_stop_bad = 1'b1; w_state_nxt = S_BREAK_CHK; end
      end
      S_BREAK_CHK: begin
        if (rx) w_state_nxt = S_WAIT_IDLE;
        else if (w_tmr_zero && !r_brk_done) w_brk = 1'b1;
      end
      default: w_state_nxt = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_WAIT_IDLE;
      r_bit_tmr   <= '0;
      r_div       <= '0;
      r_bit_idx   <= '0;
      r_sh        <= '0;
      r_idle_tmr  <= '0;
      r_idle_cnt  <= '0;
      r_rate_hs   <= 1'b0;
      r_crc       <= CRC_INIT;
      r_brk_done  <= 1'b0;
      data        <= '0;
      data_clk    <= 1'b0;
      crc_eq_zero <= 1'b0;
      bus_idle    <= 1'b0;
      rx_break    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_clk  <= 1'b0;
      rx_break  <= 1'b0;
      frame_err <= 1'b0;
      if (force_wait_idle) begin
        // Drops any word in flight, including one at its stop sample.
        r_state    <= S_WAIT_IDLE;
        bus_idle   <= 1'b0;
        r_idle_tmr <= '0;
        r_idle_cnt <= '0;
      end else begin
        r_state <= w_state_nxt;

        // Idle counters only run while waiting; any other state restarts them
        // so the count measures high time since the last frame activity.
        if (!w_idle_st || !rx) begin
          r_idle_tmr <= '0;
          r_idle_cnt <= '0;
        end else if (w_idle_tick) begin
          r_idle_tmr <= '0;
          if (!(&r_idle_cnt)) r_idle_cnt <= r_idle_cnt + (IDLE_W+1)'(1);
        end else begin
          r_idle_tmr <= r_idle_tmr + DIV_W'(1);
        end
        if (w_idle_hit) begin
          bus_idle   <= 1'b1;
          r_crc      <= CRC_INIT;
          r_rate_hs  <= 1'b0;
          r_idle_cnt <= '0;
        end

        // Bit timer: half period to the start-bit centre, then full periods.
        // After a bad stop the remaining half bit brings total low time to
        // DATA_W+2 bit-times. The timer holds at zero.
        if (w_start) begin
          r_div     <= w_div_sel;
          r_bit_tmr <= {1'b0, w_div_sel} >> 1;
        end else if (w_stop_bad) begin
          r_bit_tmr <= {1'b0, r_div} >> 1;
        end else if (w_start_ok || w_bit) begin
          r_bit_tmr <= {1'b0, r_div};
        end else if (!w_tmr_zero) begin
          r_bit_tmr <= r_bit_tmr - (DIV_W+1)'(1);
        end

        if (w_start_ok) begin
          bus_idle  <= 1'b0;
          r_bit_idx <= '0;
        end
        if (w_bit) begin
          r_sh      <= {rx, r_sh[DATA_W-1:1]};
          r_bit_idx <= r_bit_idx + IDX_W'(1);
        end
        if (w_stop_ok) begin
          data        <= r_sh;
          data_clk    <= 1'b1;
          r_crc       <= w_crc_nxt;
          crc_eq_zero <= (w_crc_nxt == 16'h0000);
          r_rate_hs   <= 1'b1;
        end
        if (w_stop_bad) begin
          frame_err  <= 1'b1;
          r_brk_done <= 1'b0;
        end
        if (w_brk) begin
          rx_break   <= 1'b1;
          r_brk_done <= 1'b1;
        end
      end
    end
  end

endmodule
